// File: rtl/disp_scan_if.sv
// Display front-end signal bundle: CPU-side inputs into disp_scan and the
// display/key-derived outputs back out. Master drives the inputs; slave is disp_scan.
interface disp_scan_if;
  logic [1:0]  cpustate;
  logic        key_n;
  logic [7:0]  D;
  logic [7:0]  check_out;
  logic [7:0]  bus_data;
  logic [15:0] addr;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        step;
  logic [4:0]  index;

  modport master (
    output cpustate, key_n, D, check_out, bus_data, addr,
    input  an, seg, step, index
  );

  modport slave (
    input  cpustate, key_n, D, check_out, bus_data, addr,
    output an, seg, step, index
  );
endinterface

// File: rtl/disp_scan.sv
// Multiplexed 4-digit active-low 7-segment driver with a debounced step key
// that maintains a 5-bit shadow of the memory entry index.
module disp_scan #(
  parameter int SCAN_DIV   = 16,
  parameter int DEB_CYCLES = 3
) (
  input logic        clk,
  input logic        reset,
  disp_scan_if.slave bus
);
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          r_sync1, r_sync2;
  logic          r_kdb, r_kdb_d;
  logic [DW-1:0] r_dcnt;
  logic          r_step;
  logic [4:0]    r_index;
  logic [SW-1:0] r_scnt;
  logic [1:0]    r_dsel;
  logic [3:0]    r_an;
  logic [7:0]    r_seg;

  logic [3:0]    w_nib;
  logic [6:0]    w_hex;
  logic          w_dp;
  logic          w_blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Key path: the debounced level only moves after DEB_CYCLES consecutive
  // disagreeing samples; step is taken from the registered falling edge of kdb.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_kdb   <= 1'b1;
      r_kdb_d <= 1'b1;
      r_dcnt  <= '0;
      r_step  <= 1'b0;
    end else begin
      r_sync1 <= bus.key_n;
      r_sync2 <= r_sync1;
      r_kdb_d <= r_kdb;
      r_step  <= r_kdb_d & ~r_kdb;
      if (r_sync2 != r_kdb) begin
        if (r_dcnt == DW'(DEB_CYCLES - 1)) begin
          r_kdb  <= r_sync2;
          r_dcnt <= '0;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end else begin
        r_dcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_index <= '0;
    end else if (r_step && (bus.cpustate == 2'b01 || bus.cpustate == 2'b10)) begin
      r_index <= r_index + 5'd1;
    end
  end

  // The scan keeps running while blank so resuming is phase-continuous.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scnt <= '0;
      r_dsel <= 2'd0;
    end else if (r_scnt == SW'(SCAN_DIV - 1)) begin
      r_scnt <= '0;
      r_dsel <= r_dsel + 2'd1;
    end else begin
      r_scnt <= r_scnt + 1'b1;
    end
  end

  always_comb begin
    w_nib = 4'h0;
    case (bus.cpustate)
      2'b01: begin
        case (r_dsel)
          2'd0:    w_nib = bus.D[3:0];
          2'd1:    w_nib = bus.D[7:4];
          2'd2:    w_nib = r_index[3:0];
          default: w_nib = {3'b000, r_index[4]};
        endcase
      end
      2'b10: begin
        case (r_dsel)
          2'd0:    w_nib = bus.check_out[3:0];
          2'd1:    w_nib = bus.check_out[7:4];
          2'd2:    w_nib = r_index[3:0];
          default: w_nib = {3'b000, r_index[4]};
        endcase
      end
      2'b11: begin
        case (r_dsel)
          2'd0:    w_nib = bus.bus_data[3:0];
          2'd1:    w_nib = bus.bus_data[7:4];
          2'd2:    w_nib = bus.addr[3:0];
          default: w_nib = bus.addr[7:4];
        endcase
      end
      default: w_nib = 4'h0;
    endcase
  end

  assign w_hex   = hex7(w_nib);
  assign w_blank = (bus.cpustate == 2'b00);
  // dp marks an address above page 0 on the low address digit.
  assign w_dp    = ~((bus.cpustate == 2'b11) && (r_dsel == 2'd2) && (bus.addr[15:8] != 8'h00));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an  <= 4'hF;
      r_seg <= 8'hFF;
    end else if (w_blank) begin
      r_an  <= 4'hF;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= ~(4'b0001 << r_dsel);
      r_seg <= {w_dp, w_hex};
    end
  end

  assign bus.an    = r_an;
  assign bus.seg   = r_seg;
  assign bus.step  = r_step;
  assign bus.index = r_index;
endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan: digit/segment vector table plus key, index,
// blanking and reset sequences.
module tb_disp_scan;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  disp_scan_if bus();

  disp_scan #(.SCAN_DIV(16), .DEB_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  cs;
    logic [7:0]  d;
    logic [7:0]  chk;
    logic [7:0]  bd;
    logic [15:0] addr;
    int          dig;
    logic [3:0]  an;
    logic [7:0]  seg;
  } vec_t;

  vec_t        vecs[26];
  logic [11:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc;

  // Edges since reset release; digit shown after edge k is ((k-1)/16)%4.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [1:0] cs, input logic [7:0] d,
                      input logic [7:0] chk, input logic [7:0] bd, input logic [15:0] a,
                      input int dig, input logic [3:0] an, input logic [7:0] seg);
    vecs[i].cs = cs;  vecs[i].d = d;     vecs[i].chk = chk; vecs[i].bd = bd;
    vecs[i].addr = a; vecs[i].dig = dig; vecs[i].an = an;   vecs[i].seg = seg;
  endtask

  task automatic wait_digit(input int d, output bit found);
    int k;
    found = 0;
    k = 0;
    @(negedge clk);
    while (!found && k < 80) begin
      if (cyc >= 1 && ((cyc - 1) / 16) % 4 == d) found = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
  endtask

  task automatic apply(input int lo, input int hi);
    bit          found;
    logic [11:0] e;
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      bus.cpustate  = vecs[i].cs;
      bus.D         = vecs[i].d;
      bus.check_out = vecs[i].chk;
      bus.bus_data  = vecs[i].bd;
      bus.addr      = vecs[i].addr;
      exp_q.push_back({vecs[i].an, vecs[i].seg});
      wait_digit(vecs[i].dig, found);
      e = exp_q.pop_front();
      if (!found) check($sformatf("vec%0d_timeout", i), 32'd0, 32'd1);
      else begin
        check($sformatf("vec%0d_an", i), {28'd0, bus.an}, {28'd0, e[11:8]});
        check($sformatf("vec%0d_seg", i), {24'd0, bus.seg}, {24'd0, e[7:0]});
      end
    end
  endtask

  // Key held low for 'low' sampling edges; lat is the negedge index after
  // the press edge at which step was first seen (n+5 edges -> 6).
  task automatic press(input int low, output int pulses, output int lat);
    pulses = 0;
    lat = 0;
    @(negedge clk);
    bus.key_n = 1'b0;
    for (int k = 1; k <= low + 20; k++) begin
      @(negedge clk);
      if (k == low) bus.key_n = 1'b1;
      if (bus.step === 1'b1) begin
        pulses++;
        if (lat == 0) lat = k;
      end
    end
  endtask

  task automatic press_n(input int n);
    int p, l;
    for (int i = 0; i < n; i++) begin
      press(6, p, l);
      check("multi_press_pulse", p, 1);
    end
  endtask

  initial begin
    int p, l;
    setv(0,  2'b01, 8'hA5, 8'h00, 8'h00, 16'h0000, 0, 4'hE, 8'h92);
    setv(1,  2'b01, 8'hA5, 8'h00, 8'h00, 16'h0000, 1, 4'hD, 8'h88);
    setv(2,  2'b01, 8'hA5, 8'h00, 8'h00, 16'h0000, 2, 4'hB, 8'hC0);
    setv(3,  2'b01, 8'hA5, 8'h00, 8'h00, 16'h0000, 3, 4'h7, 8'hC0);
    setv(4,  2'b10, 8'h00, 8'h3F, 8'h00, 16'h0000, 0, 4'hE, 8'h8E);
    setv(5,  2'b10, 8'h00, 8'h3F, 8'h00, 16'h0000, 1, 4'hD, 8'hB0);
    setv(6,  2'b10, 8'h00, 8'h3F, 8'h00, 16'h0000, 2, 4'hB, 8'h92);
    setv(7,  2'b10, 8'h00, 8'h3F, 8'h00, 16'h0000, 3, 4'h7, 8'hC0);
    setv(8,  2'b11, 8'h00, 8'h00, 8'h01, 16'h0120, 0, 4'hE, 8'hF9);
    setv(9,  2'b11, 8'h00, 8'h00, 8'h01, 16'h0120, 1, 4'hD, 8'hC0);
    setv(10, 2'b11, 8'h00, 8'h00, 8'h01, 16'h0120, 2, 4'hB, 8'h40);
    setv(11, 2'b11, 8'h00, 8'h00, 8'h01, 16'h0120, 3, 4'h7, 8'hA4);
    setv(12, 2'b11, 8'h00, 8'h00, 8'h01, 16'h0020, 2, 4'hB, 8'hC0);
    setv(13, 2'b11, 8'h00, 8'h00, 8'h01, 16'h0020, 3, 4'h7, 8'hA4);
    setv(14, 2'b11, 8'h00, 8'h00, 8'hC6, 16'hFF9B, 0, 4'hE, 8'h82);
    setv(15, 2'b11, 8'h00, 8'h00, 8'hC6, 16'hFF9B, 1, 4'hD, 8'hC6);
    setv(16, 2'b11, 8'h00, 8'h00, 8'hC6, 16'hFF9B, 2, 4'hB, 8'h03);
    setv(17, 2'b11, 8'h00, 8'h00, 8'hC6, 16'hFF9B, 3, 4'h7, 8'h90);
    setv(18, 2'b11, 8'h00, 8'h00, 8'h80, 16'h0000, 0, 4'hE, 8'hC0);
    setv(19, 2'b11, 8'h00, 8'h00, 8'h80, 16'h0000, 1, 4'hD, 8'h80);
    setv(20, 2'b01, 8'h7E, 8'h00, 8'h00, 16'h0000, 0, 4'hE, 8'h86);
    setv(21, 2'b01, 8'h7E, 8'h00, 8'h00, 16'h0000, 1, 4'hD, 8'hF8);
    setv(22, 2'b01, 8'h7E, 8'h00, 8'h00, 16'h0000, 2, 4'hB, 8'h8E);
    setv(23, 2'b01, 8'h7E, 8'h00, 8'h00, 16'h0000, 3, 4'h7, 8'hF9);
    setv(24, 2'b01, 8'h4D, 8'h00, 8'h00, 16'h0000, 0, 4'hE, 8'hA1);
    setv(25, 2'b01, 8'h4D, 8'h00, 8'h00, 16'h0000, 1, 4'hD, 8'h99);

    // Reset and first scan digit timing
    reset = 1'b0;
    bus.cpustate = 2'b01; bus.key_n = 1'b1; bus.D = 8'hA5;
    bus.check_out = 8'h00; bus.bus_data = 8'h00; bus.addr = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_an", {28'd0, bus.an}, 32'hF);
    check("rst_seg", {24'd0, bus.seg}, 32'hFF);
    check("rst_index", {27'd0, bus.index}, 32'd0);
    check("rst_step", {31'd0, bus.step}, 32'd0);
    reset = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check($sformatf("scan_an_k%0d", k), {28'd0, bus.an}, (k <= 16) ? 32'hE : 32'hD);
    end

    apply(0, 3);

    // Debounce: short glitch, then a real press with latency check
    press(2, p, l);
    check("glitch_pulses", p, 0);
    check("glitch_index", {27'd0, bus.index}, 32'd0);
    press(10, p, l);
    check("press_pulses", p, 1);
    check("press_latency", l, 6);
    check("press_index", {27'd0, bus.index}, 32'd1);
    press_n(4);
    check("index_5", {27'd0, bus.index}, 32'd5);

    apply(4, 7);

    // A press in RUN steps but leaves index alone
    @(negedge clk);
    bus.cpustate = 2'b11;
    press(10, p, l);
    check("run_press_pulses", p, 1);
    check("run_press_index", {27'd0, bus.index}, 32'd5);

    apply(8, 19);

    // Blank on the next edge; index holds in idle
    @(negedge clk);
    bus.cpustate = 2'b00;
    @(negedge clk);
    check("idle_an", {28'd0, bus.an}, 32'hF);
    check("idle_seg", {24'd0, bus.seg}, 32'hFF);
    press(10, p, l);
    check("idle_press_pulses", p, 1);
    check("idle_press_index", {27'd0, bus.index}, 32'd5);

    // Walk index to 31, show it, then wrap to 0
    @(negedge clk);
    bus.cpustate = 2'b01;
    press_n(26);
    check("index_31", {27'd0, bus.index}, 32'd31);
    apply(20, 25);
    press_n(1);
    check("index_wrap", {27'd0, bus.index}, 32'd0);
    press_n(2);
    check("index_2", {27'd0, bus.index}, 32'd2);

    // Reset during a debounce count
    @(negedge clk);
    bus.key_n = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_an", {28'd0, bus.an}, 32'hF);
    check("midrst_seg", {24'd0, bus.seg}, 32'hFF);
    check("midrst_index", {27'd0, bus.index}, 32'd0);
    @(negedge clk);
    bus.key_n = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    p = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.step === 1'b1) p++;
    end
    check("midrst_pulses", p, 0);
    check("midrst_index_after", {27'd0, bus.index}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
